// File: rtl/td_rf_seq.sv
// td_rf_seq
// Command-driven sequencer for the 8-entry time-domain register file.
// WRITE turns a digital length into a timed write-enable pulse. CLEAR holds
// the file's active-low clear for a fixed number of cycles. READ opens the
// read-enable window and measures, in clock cycles, when the two
// asynchronous register-file outputs rise.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_op                    00 NOP, 01 WRITE, 10 READ, 11 CLEAR
//   cmd_addr_a, cmd_addr_b    write / port-a address, port-b read address
//   cmd_data, cmd_fb          write pulse length and feedback request
//   rsp_valid / rsp_ready     read result handshake
//   rsp_a, rsp_b, rsp_to      measured rise times and timeout flags {b, a}
//   rf_we, rf_fb, rf_re       register-file write, feedback, read enables
//   rf_wsel, rf_ra, rf_rb     register-file write and read selects
//   rf_rst_n                  active-low register-file clear
//   rf_a, rf_b                asynchronous register-file outputs
module td_rf_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 254,
  parameter int RST_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_addr_a,
  input  logic [2:0]       cmd_addr_b,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic             cmd_fb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_a,
  output logic [CNT_W-1:0] rsp_b,
  output logic [1:0]       rsp_to,
  output logic             rf_we,
  output logic             rf_fb,
  output logic             rf_re,
  output logic [2:0]       rf_wsel,
  output logic [2:0]       rf_ra,
  output logic [2:0]       rf_rb,
  output logic             rf_rst_n,
  input  logic             rf_a,
  input  logic             rf_b
);

  typedef enum logic [3:0] {
    CLR, IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_MEASURE, R_RECOVER, RESP
  } state_t;

  localparam logic [1:0]       OP_WRITE = 2'b01;
  localparam logic [1:0]       OP_READ  = 2'b10;
  localparam logic [1:0]       OP_CLEAR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             fb_q, fb_d;
  logic [2:0]       wsel_q, wsel_d, ra_q, ra_d, rb_q, rb_d;
  logic             a_meta_q, a_meta_d, b_meta_q, b_meta_d;
  logic             a_done_q, a_done_d, b_done_q, b_done_d;
  logic [CNT_W-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [1:0]       rsp_to_q, rsp_to_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             we_q, we_d, fbo_q, fbo_d, re_q, re_d, rst_n_q, rst_n_d;
  logic             a_s, b_s;

  // The first synchronizer stage feeds the capture logic directly; the
  // done flag and the captured count act as the second stage. This gives a
  // capture of j + 2 for an input that rises just after measure cycle j.
  assign a_s = a_meta_q;
  assign b_s = b_meta_q;

  // Next-state logic. One shared counter serves the clear length, the write
  // pulse length and the read measurement, since only one is active at a time.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fb_d     = fb_q;
    wsel_d   = wsel_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    a_meta_d = rf_a;
    b_meta_d = rf_b;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
    rsp_a_d  = rsp_a_q;
    rsp_b_d  = rsp_b_q;
    rsp_to_d = rsp_to_q;

    case (state_q)
      CLR: begin
        if (cnt_q == RST_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              state_d = W_SETUP;
              wsel_d  = cmd_addr_a;
              data_d  = cmd_data;
              fb_d    = cmd_fb;
            end
            OP_READ: begin
              state_d = R_SETUP;
              ra_d    = cmd_addr_a;
              rb_d    = cmd_addr_b;
            end
            OP_CLEAR: begin
              state_d = CLR;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      W_SETUP: begin
        // A zero length skips the pulse entirely.
        if (data_q == '0) begin
          state_d = W_HOLD;
        end else begin
          state_d = W_PULSE;
          cnt_d   = CNT_ONE;
        end
      end
      W_PULSE: begin
        if (cnt_q == data_q) state_d = W_HOLD;
        else                 cnt_d   = cnt_q + CNT_ONE;
      end
      W_HOLD: state_d = IDLE;
      R_SETUP: begin
        state_d  = R_MEASURE;
        cnt_d    = '0;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
      end
      R_MEASURE: begin
        if (a_s && !a_done_q) begin
          a_done_d = 1'b1;
          rsp_a_d  = cnt_q;
        end
        if (b_s && !b_done_q) begin
          b_done_d = 1'b1;
          rsp_b_d  = cnt_q;
        end
        if ((a_done_d && b_done_d) || (cnt_q == TO_LAST)) begin
          state_d  = R_RECOVER;
          if (!a_done_d) rsp_a_d = '1;
          if (!b_done_d) rsp_b_d = '1;
          rsp_to_d = {!b_done_d, !a_done_d};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      R_RECOVER: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = CLR;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    we_d        = (state_d == W_PULSE);
    fbo_d       = (state_d == W_PULSE) && fb_q;
    re_d        = (state_d == R_MEASURE);
    rst_n_d     = (state_d != CLR);
  end

  // State and output registers; reset drops every enable at once so no
  // partial pulse outlives the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLR;
      cnt_q       <= '0;
      data_q      <= '0;
      fb_q        <= 1'b0;
      wsel_q      <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      a_meta_q    <= 1'b0;
      b_meta_q    <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_to_q    <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      fbo_q       <= 1'b0;
      re_q        <= 1'b0;
      rst_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      fb_q        <= fb_d;
      wsel_q      <= wsel_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      a_meta_q    <= a_meta_d;
      b_meta_q    <= b_meta_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_to_q    <= rsp_to_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      fbo_q       <= fbo_d;
      re_q        <= re_d;
      rst_n_q     <= rst_n_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign rsp_to    = rsp_to_q;
  assign rf_we     = we_q;
  assign rf_fb     = fbo_q;
  assign rf_re     = re_q;
  assign rf_wsel   = wsel_q;
  assign rf_ra     = ra_q;
  assign rf_rb     = rb_q;
  assign rf_rst_n  = rst_n_q;

endmodule

// File: tb/tb_td_rf_seq.sv
// tb_td_rf_seq
// Self-checking bench for td_rf_seq: directed cases followed by random
// commands. Expected pulse lengths, busy times, capture values and latencies
// come from a small behavioural model of the command rules.
module tb_td_rf_seq;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 254;
  localparam int RST_CYC = 4;
  localparam int ALL_ONES = (1 << CNT_W) - 1;
  localparam int NEVER    = 1 << 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_addr_a;
  logic [2:0]       cmd_addr_b;
  logic [CNT_W-1:0] cmd_data;
  logic             cmd_fb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_a;
  logic [CNT_W-1:0] rsp_b;
  logic [1:0]       rsp_to;
  logic             rf_we, rf_fb, rf_re;
  logic [2:0]       rf_wsel, rf_ra, rf_rb;
  logic             rf_rst_n;
  logic             rf_a, rf_b;

  int checks   = 0;
  int failures = 0;

  td_rf_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_data(cmd_data), .cmd_fb(cmd_fb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_to(rsp_to),
    .rf_we(rf_we), .rf_fb(rf_fb), .rf_re(rf_re),
    .rf_wsel(rf_wsel), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_rst_n(rf_rst_n), .rf_a(rf_a), .rf_b(rf_b)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one command and returns one time step after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] aa, input logic [2:0] ab,
                               input logic [CNT_W-1:0] d, input logic f);
    bit ok = 1'b0;
    cmd_op = op; cmd_addr_a = aa; cmd_addr_b = ab; cmd_data = d; cmd_fb = f;
    cmd_valid = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic resetValuesCheck();
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_a", rsp_a, 0);
    checkOutput("rst_rsp_b", rsp_b, 0);
    checkOutput("rst_rsp_to", rsp_to, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_fb", rf_fb, 0);
    checkOutput("rst_rf_re", rf_re, 0);
    checkOutput("rst_rf_wsel", rf_wsel, 0);
    checkOutput("rst_rf_ra", rf_ra, 0);
    checkOutput("rst_rf_rb", rf_rb, 0);
    checkOutput("rst_rf_rst_n", rf_rst_n, 0);
  endtask

  // Counts how long the clear stays low; cmd_ready must rise with it.
  task automatic countClearLow(input string tag);
    int low = 0;
    bit up  = 1'b0;
    for (int k = 0; k < 20 && !up; k++) begin
      @(negedge clk);
      if (rf_rst_n) up = 1'b1;
      else begin
        low++;
        checkOutput({tag, "_busy_ready"}, cmd_ready, 0);
      end
    end
    checkOutput({tag, "_low_cycles"}, low, RST_CYC);
    checkOutput({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    countClearLow("rst");
  endtask

  task automatic doWrite(input logic [2:0] addr, input int data, input bit fb);
    int busy = 0, we_n = 0, fb_n = 0, first = -1, last = -1, wsel_seen = -1;
    bit done = 1'b0;
    applyStimulus(2'b01, addr, 3'd0, CNT_W'(data), fb);
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      else begin
        if (busy == 0) wsel_seen = rf_wsel;
        if (rf_we) begin
          if (first < 0) first = busy;
          last = busy;
          we_n++;
        end
        if (rf_fb) fb_n++;
        busy++;
      end
    end
    checkOutput("w_busy", busy, data + 2);
    checkOutput("w_pulse_len", we_n, data);
    checkOutput("w_fb_len", fb_n, fb ? data : 0);
    checkOutput("w_wsel", wsel_seen, addr);
    if (data > 0) begin
      checkOutput("w_pulse_start", first, 1);
      checkOutput("w_pulse_contig", last - first + 1, data);
    end
  endtask

  task automatic doNop();
    applyStimulus(2'b00, 3'd0, 3'd0, '0, 1'b0);
    @(negedge clk);
    checkOutput("nop_ready", cmd_ready, 1);
    checkOutput("nop_we", rf_we, 0);
    checkOutput("nop_rsp_valid", rsp_valid, 0);
  endtask

  task automatic doClear();
    applyStimulus(2'b11, 3'd0, 3'd0, '0, 1'b0);
    countClearLow("clr");
  endtask

  // ja/jb: measure cycle after which the line rises; -1 = high before the
  // read, -2 = never rises.
  task automatic doRead(input logic [2:0] ra, input logic [2:0] rb, input int ja, input int jb,
                        input int hold, input bit pend_clr);
    int cap_a, cap_b, end_cnt, exp_m, exp_a, exp_b, exp_to;
    int re_n = 0, lat = 0, seen_ra = -1, seen_rb = -1;
    bit got = 1'b0, up_a = 1'b0, up_b = 1'b0;

    cap_a = (ja == -1) ? 0 : (ja == -2) ? NEVER : ja + 2;
    cap_b = (jb == -1) ? 0 : (jb == -2) ? NEVER : jb + 2;
    end_cnt = (cap_a > cap_b) ? cap_a : cap_b;
    if (end_cnt > TIMEOUT) end_cnt = TIMEOUT;
    exp_m  = end_cnt + 1;
    exp_a  = (cap_a <= TIMEOUT) ? cap_a : ALL_ONES;
    exp_b  = (cap_b <= TIMEOUT) ? cap_b : ALL_ONES;
    exp_to = ((cap_b > TIMEOUT) ? 2 : 0) + ((cap_a > TIMEOUT) ? 1 : 0);

    rf_a = (ja == -1);
    rf_b = (jb == -1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(2'b10, ra, rb, '0, 1'b0);
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (rf_re) begin
        if (re_n == 0) begin
          seen_ra = rf_ra;
          seen_rb = rf_rb;
        end
        if (re_n == ja) up_a = 1'b1;
        if (re_n == jb) up_b = 1'b1;
        re_n++;
      end
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if (up_a) rf_a = 1'b1;
        if (up_b) rf_b = 1'b1;
      end
    end
    checkOutput("r_rsp_seen", got, 1);
    checkOutput("r_latency", lat, exp_m + 3);
    checkOutput("r_re_len", re_n, exp_m);
    checkOutput("r_ra", seen_ra, ra);
    checkOutput("r_rb", seen_rb, rb);
    checkOutput("r_rsp_a", rsp_a, exp_a);
    checkOutput("r_rsp_b", rsp_b, exp_b);
    checkOutput("r_rsp_to", rsp_to, exp_to);

    if (pend_clr) begin
      cmd_op    = 2'b11;
      cmd_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_a", rsp_a, exp_a);
      checkOutput("bp_rsp_b", rsp_b, exp_b);
      checkOutput("bp_rsp_to", rsp_to, exp_to);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_rf_rst_n", rf_rst_n, 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("hs_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("hs_rsp_done", rsp_valid, 0);
    checkOutput("hs_rf_rst_n", rf_rst_n, 1);
    rf_a = 1'b0;
    rf_b = 1'b0;
  endtask

  task automatic midWriteReset();
    bit seen = 1'b0;
    applyStimulus(2'b01, 3'd5, 3'd0, CNT_W'(10), 1'b1);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rf_we) seen = 1'b1;
    end
    @(negedge clk);
    checkOutput("mid_we_before_rst", rf_we, 1);
    #3 rst = 1'b1;
    #1 resetValuesCheck();
    releaseReset();
  endtask

  function automatic int pickRise();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return -1;
    if (r == 1) return -2;
    return $urandom_range(0, 30);
  endfunction

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = 3'd0; cmd_addr_b = 3'd0;
    cmd_data = '0; cmd_fb = 1'b0; rsp_ready = 1'b0; rf_a = 1'b0; rf_b = 1'b0;
    #3 resetValuesCheck();
    releaseReset();

    doWrite(3'd5, 3, 1'b1);
    doWrite(3'd1, 0, 1'b0);
    doNop();
    doRead(3'd2, 3'd6, 4, 9, 0, 1'b0);
    doRead(3'd3, 3'd3, -1, -2, 0, 1'b0);
    doRead(3'd4, 3'd1, 3, 7, 10, 1'b1);
    doClear();
    midWriteReset();

    for (int i = 0; i < 25; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3)
        doWrite(3'($urandom_range(0, 7)), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      else if (op <= 7)
        doRead(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), pickRise(), pickRise(),
               $urandom_range(0, 4), 1'b0);
      else if (op == 8)
        doNop();
      else
        doClear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
